mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter W, default 8: data width of each requester lane and of Y.
REQ-002 Parameter HOLD_MAX, default 4: maximum consecutive granted cycles before preemption when others wait; legal range 1..15.
REQ-003 Port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port req, input, 4: req[i] high = requester i wants the shared 4:1 mux path.
REQ-006 Port D, input, 4*W: requester lanes; lane i = D[i*W +: W].
REQ-007 Port gnt, output, 4: registered one-hot grant; all zero when no owner.
REQ-008 Port sel, output, 2: registered binary index of current or most recent owner; drives the mux select.
REQ-009 Port busy, output, 1: registered; high exactly when gnt is non-zero.
REQ-010 Port Y, output, W: combinational; equals lane sel when busy=1, else all zeros.

Function
REQ-011 Two states SHALL exist: IDLE (no owner) and OWN (one owner, index = sel).
REQ-012 Internal hold_cnt (4 bits) SHALL count granted cycles of the current owner: load 1 on each new grant, increment each OWN cycle the same owner is kept, saturate at HOLD_MAX.
REQ-013 Round-robin search SHALL scan indices ptr+1, ptr+2, ptr+3, ptr (mod 4), where ptr = sel, and pick the first index whose req bit is high.
REQ-014 IDLE: if req != 0 at a rising edge, the searched winner SHALL be granted at that edge (gnt, sel, busy valid in the following cycle), state -> OWN; if req == 0, stay IDLE, sel unchanged.
REQ-015 OWN, req[sel]=0 (release): if any other req high, grant the searched winner at that same edge with no idle bubble; else -> IDLE, gnt=0, busy=0, sel unchanged.
REQ-016 OWN, req[sel]=1, hold_cnt < HOLD_MAX: keep owner, gnt/sel unchanged.
REQ-017 OWN, req[sel]=1, hold_cnt == HOLD_MAX, some other req high: preempt; grant the searched winner (owner is lowest priority by REQ-013) at that edge.
REQ-018 OWN, req[sel]=1, hold_cnt == HOLD_MAX, no other req high: keep owner; hold_cnt stays saturated.
REQ-019 Grant latency SHALL be exactly one clock from the edge sampling the deciding req; no combinational path from req to gnt, sel or busy.
REQ-020 gnt SHALL always be one-hot or zero; gnt[sel]=1 whenever busy=1.
REQ-021 Y SHALL follow D combinationally within the cycle (mux path only, no register).
REQ-022 A requester SHALL not be granted two consecutive tenures while another requester holds req high throughout (fairness bound: wait <= 3*HOLD_MAX cycles).

Reset
REQ-023 With rst=1 at a rising edge: state IDLE, gnt=0, busy=0, sel=2'd3, hold_cnt=0, so the first search starts at index 0.
REQ-024 rst SHALL dominate all other inputs, including mid-tenure; ownership is dropped and Y returns to zero in the next cycle.
REQ-025 Y SHALL be zero during and immediately after reset regardless of D.

Verification
REQ-026 After reset, req=4'b1111 -> gnt=0001, sel=0 next cycle; with all req held and HOLD_MAX=4, grants rotate 0,1,2,3,0 every 4 cycles.
REQ-027 Owner 2 drops req while req=4'b1001 pending -> next cycle gnt=1000, sel=3, busy stays 1 (no bubble).
REQ-028 Single requester 1 held for 10 cycles, others low -> gnt=0010 continuously, no preemption, Y=lane 1 throughout.
REQ-029 D lanes = 8'hA0,8'hB1,8'hC2,8'hD3, owner sel=2 -> Y=8'hC2; all req low -> Y=8'h00, busy=0, sel remains 2.
REQ-030 rst asserted mid-tenure of owner 1 with req=4'b1111 -> next cycle gnt=0, busy=0, sel=3; rst released with req held -> gnt=0001 one cycle later.
REQ-031 Assertion check over random req: gnt one-hot-or-zero, busy == |gnt, gnt[sel]==busy, fairness bound of REQ-022 never violated.

Source files
------------

// File: rtl/mux4_rr_arbiter.sv
// mux4_rr_arbiter
//   Four requesters share one W-bit 4:1 mux path. A round-robin arbiter with
//   a bounded tenure (HOLD_MAX cycles while others wait) decides which lane
//   drives Y.
//
// Ports
//   clk   : clock, all state changes on the rising edge
//   rst   : synchronous active-high reset
//   req   : [3:0] request bits, req[i] = requester i wants the path
//   D     : [4*W-1:0] requester lanes, lane i = D[i*W +: W]
//   gnt   : [3:0] registered one-hot grant, zero when there is no owner
//   sel   : [1:0] registered index of the current or most recent owner
//   busy  : registered, high exactly when gnt is non-zero
//   Y     : [W-1:0] combinational mux output, lane sel when busy, else zero
module mux4_rr_arbiter #(
  parameter int W        = 8,
  parameter int HOLD_MAX = 4   // legal range 1..15, fits the 4-bit hold counter
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [3:0]     req,
  input  logic [4*W-1:0] D,
  output logic [3:0]     gnt,
  output logic [1:0]     sel,
  output logic           busy,
  output logic [W-1:0]   Y
);

  typedef enum logic {IDLE, OWN} state_t;

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  state_t     state, state_nxt;
  logic [3:0] gnt_nxt;
  logic [1:0] sel_nxt;
  logic       busy_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic [2:0] pick;     // {found, index} from the round-robin search
  logic       others;   // some requester other than sel is asking

  // Round-robin search starting after ptr: ptr+1, ptr+2, ptr+3, ptr.
  // Scanning from the far end lets the nearest hit overwrite earlier ones,
  // so the current pointer itself is the lowest-priority candidate.
  function automatic logic [2:0] rr_pick(input logic [3:0] r, input logic [1:0] ptr);
    logic [1:0] idx;
    rr_pick = 3'b000;
    for (int k = 4; k >= 1; k--) begin
      idx = ptr + 2'(k);
      if (r[idx]) rr_pick = {1'b1, idx};
    end
  endfunction

  always_comb begin
    state_nxt = state;
    gnt_nxt   = gnt;
    sel_nxt   = sel;
    busy_nxt  = busy;
    hold_nxt  = hold_cnt;
    pick      = rr_pick(req, sel);
    others    = |(req & ~(4'b0001 << sel));

    unique case (state)
      IDLE: begin
        if (pick[2]) begin
          state_nxt = OWN;
          sel_nxt   = pick[1:0];
          gnt_nxt   = 4'b0001 << pick[1:0];
          busy_nxt  = 1'b1;
          hold_nxt  = 4'd1;
        end
      end
      OWN: begin
        if (!req[sel]) begin
          // Release: hand straight over when someone else waits, no bubble.
          if (pick[2]) begin
            sel_nxt  = pick[1:0];
            gnt_nxt  = 4'b0001 << pick[1:0];
            hold_nxt = 4'd1;
          end else begin
            state_nxt = IDLE;
            gnt_nxt   = 4'b0000;
            busy_nxt  = 1'b0;
            hold_nxt  = 4'd0;
          end
        end else if (hold_cnt < HOLD_LIM) begin
          hold_nxt = hold_cnt + 4'd1;
        end else if (others) begin
          // Tenure expired with a waiter: the owner sits last in the search,
          // so the pick is guaranteed to be a different requester.
          sel_nxt  = pick[1:0];
          gnt_nxt  = 4'b0001 << pick[1:0];
          hold_nxt = 4'd1;
        end
      end
      default: begin
        state_nxt = IDLE;
        gnt_nxt   = 4'b0000;
        busy_nxt  = 1'b0;
        hold_nxt  = 4'd0;
      end
    endcase
  end

  // State register; sel resets to 3 so the first search begins at index 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      gnt      <= 4'b0000;
      sel      <= 2'd3;
      busy     <= 1'b0;
      hold_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      busy     <= busy_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  // Output mux; rst forces zero so Y is quiet while reset is applied.
  always_comb begin
    Y = '0;
    if (busy && !rst) Y = D[sel*W +: W];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// tb_mux4_rr_arbiter
//   Directed and random stimulus for mux4_rr_arbiter. A behavioural model
//   predicts gnt/sel/busy/Y for every driven cycle; predictions are queued
//   when stimulus is applied and popped when the DUT output is sampled.
module tb_mux4_rr_arbiter;
  localparam int W    = 8;
  localparam int HOLD = 4;

  logic           clk;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] D;
  logic [3:0]     gnt;
  logic [1:0]     sel;
  logic           busy;
  logic [W-1:0]   Y;

  mux4_rr_arbiter #(.W(W), .HOLD_MAX(HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .D(D),
    .gnt(gnt), .sel(sel), .busy(busy), .Y(Y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic         busy;
    logic [W-1:0] y;
  } exp_t;

  exp_t         sb_q[$];
  string        tag_q[$];
  logic [W-1:0] lane_v[4];
  int           n_checks = 0;
  int           n_pass   = 0;
  int           m_owner  = -1;
  int           m_sel    = 3;
  int           m_hold   = 0;
  int           wt[4]    = '{0, 0, 0, 0};
  int           max_wt   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_lanes(input logic [W-1:0] a0, input logic [W-1:0] a1,
                           input logic [W-1:0] a2, input logic [W-1:0] a3);
    lane_v[0] = a0; lane_v[1] = a1; lane_v[2] = a2; lane_v[3] = a3;
    D = {a3, a2, a1, a0};
  endtask

  // Reference arbiter: advance one rising edge given the sampled inputs.
  function automatic void model(input logic [3:0] r, input logic rs);
    bit others;
    int c;
    if (rs) begin
      m_owner = -1; m_sel = 3; m_hold = 0;
      return;
    end
    others = 0;
    for (int i = 0; i < 4; i++) if (i != m_owner && r[i]) others = 1;
    if (m_owner >= 0 && r[m_owner] && !(m_hold >= HOLD && others)) begin
      if (m_hold < HOLD) m_hold++;
    end else if (r != 4'b0000) begin
      for (int k = 1; k <= 4; k++) begin
        c = (m_sel + k) % 4;
        if (r[c]) begin
          m_owner = c; m_sel = c; m_hold = 1;
          break;
        end
      end
    end else begin
      m_owner = -1;
    end
  endfunction

  task automatic step(input logic [3:0] r, input logic rs, input string tag);
    exp_t  e;
    string t;
    req = r;
    rst = rs;
    model(r, rs);
    e.busy = (m_owner >= 0);
    e.gnt  = e.busy ? 4'(1 << m_owner) : 4'b0000;
    e.sel  = 2'(m_sel);
    e.y    = e.busy ? lane_v[m_sel] : '0;
    sb_q.push_back(e);
    tag_q.push_back(tag);
    if (rs) begin
      #1;
      chk({tag, "_y_in_rst"}, 32'(Y), 32'd0);
    end
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    t = tag_q.pop_front();
    chk({t, "_gnt"},  32'(gnt),  32'(e.gnt));
    chk({t, "_sel"},  32'(sel),  32'(e.sel));
    chk({t, "_busy"}, 32'(busy), 32'(e.busy));
    chk({t, "_y"},    32'(Y),    32'(e.y));
    for (int i = 0; i < 4; i++) begin
      if (!rs && r[i] && !gnt[i]) wt[i]++;
      else wt[i] = 0;
      if (wt[i] > max_wt) max_wt = wt[i];
    end
  endtask

  task automatic invariants(input string tag);
    chk({tag, "_onehot0"}, 32'($onehot0(gnt)), 32'd1);
    chk({tag, "_busy_or"}, 32'(busy), 32'(|gnt));
    chk({tag, "_gnt_sel"}, 32'(gnt[sel]), 32'(busy));
    chk({tag, "_fair"},    32'(max_wt <= 3 * HOLD), 32'd1);
  endtask

  initial begin
    logic [3:0] r;
    int         o;
    rst = 1'b1;
    req = 4'b0000;
    set_lanes(8'hA0, 8'hB1, 8'hC2, 8'hD3);

    step(4'b0000, 1'b1, "rst0");
    step(4'b0000, 1'b1, "rst1");
    chk("rst_gnt",  32'(gnt),  32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_sel",  32'(sel),  32'd3);
    chk("rst_y",    32'(Y),    32'd0);

    // All requesting: 0,1,2,3,0 with HOLD cycles each.
    for (int k = 0; k < 17; k++) begin
      o = (k / 4) % 4;
      step(4'b1111, 1'b0, "rot");
      chk("rot_sel_const", 32'(sel), 32'(o));
      chk("rot_gnt_const", 32'(gnt), 32'(1 << o));
    end

    // Owner 0 releases, 2 wins; then everyone drops.
    step(4'b0100, 1'b0, "to2");
    chk("own2_y_const",   32'(Y),   32'h0C2);
    chk("own2_sel_const", 32'(sel), 32'd2);
    step(4'b0000, 1'b0, "drop");
    chk("idle_y_const",    32'(Y),    32'd0);
    chk("idle_busy_const", 32'(busy), 32'd0);
    chk("idle_sel_const",  32'(sel),  32'd2);

    // Owner 2 drops with 0 and 3 pending: 3 takes over without a bubble.
    step(4'b0100, 1'b0, "g2");
    chk("g2_gnt_const", 32'(gnt), 32'b0100);
    step(4'b1101, 1'b0, "keep2");
    step(4'b1001, 1'b0, "handoff");
    chk("handoff_gnt_const",  32'(gnt),  32'b1000);
    chk("handoff_sel_const",  32'(sel),  32'd3);
    chk("handoff_busy_const", 32'(busy), 32'd1);

    // Lone requester 1 keeps the path past HOLD cycles.
    for (int k = 0; k < 10; k++) begin
      step(4'b0010, 1'b0, "solo1");
      chk("solo1_gnt_const", 32'(gnt), 32'b0010);
      chk("solo1_y_const",   32'(Y),   32'h0B1);
    end

    // Reset in the middle of owner 1's tenure with everyone requesting.
    step(4'b0000, 1'b0, "idle1");
    step(4'b0010, 1'b0, "g1");
    step(4'b1111, 1'b0, "mid1");
    chk("mid1_gnt_const", 32'(gnt), 32'b0010);
    step(4'b1111, 1'b1, "rst_mid");
    chk("rst_mid_gnt_const",  32'(gnt),  32'd0);
    chk("rst_mid_busy_const", 32'(busy), 32'd0);
    chk("rst_mid_sel_const",  32'(sel),  32'd3);
    step(4'b1111, 1'b0, "post_rst");
    chk("post_rst_gnt_const", 32'(gnt), 32'b0001);

    // Random phase: sticky requests so tenures and waits build up.
    r = 4'b0000;
    for (int k = 0; k < 400; k++) begin
      if (k % 8 == 0)
        set_lanes(W'($urandom), W'($urandom), W'($urandom), W'($urandom));
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 5) == 0) r[i] = ~r[i];
      step(r, 1'b0, "rnd");
      invariants("rnd");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
